vectadd_engine: RTL and testbench

Memory-side compute stage of the vectadd system: an Avalon-MM master that drives the second port (s2) of the 12500 × 32-bit dual-port on-chip RAM. On a start pulse it reads A[i] and B[i], writes C[i] = A[i] + B[i] for i = 0..len-1, then pulses done. Port s1 stays with the host, which loads operands and reads results.

---
 rtl/vectadd_pkg.sv | 17 +
 rtl/vectadd_engine.sv | 214 +++++++++++++++++++++
 tb/tb_vectadd_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vectadd_pkg.sv
// Shared constants and FSM state type for the vectadd compute stage.
package vectadd_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 12500;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_FIN
    } vectadd_state_t;

endpackage

// File: rtl/vectadd_engine.sv
// vectadd_engine: Avalon-MM master on RAM port s2 computing C[i] = A[i] + B[i].
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched when start is accepted
// CHECK | zero-length / range check, decides FIN or first read
// RD_A  | read request for A[i] on the bus
// RD_B  | read request for B[i]; A[i] returns and is captured into a_q
// WR    | write C[i]; B[i] returns this cycle and feeds the adder directly
// FIN   | done pulse with err/ovf valid
module vectadd_engine
    import vectadd_pkg::*;
#(
    parameter int ADDR_W = vectadd_pkg::ADDR_W,
    parameter int DATA_W = vectadd_pkg::DATA_W,
    parameter int DEPTH  = vectadd_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_a,
    input  logic [ADDR_W-1:0]     src_b,
    input  logic [ADDR_W-1:0]     dst,
    input  logic [ADDR_W-1:0]     len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

    vectadd_state_t    state_q, state_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W:0]   sum_w;
    logic [ADDR_W:0]   end_a, end_b, end_dst;
    logic              range_bad;
    logic              last_elem;

    // Adder, range check and last-element detect shared by the FSM below.
    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, mem_readdata};
        end_a     = {1'b0, src_a_q} + {1'b0, len_q};
        end_b     = {1'b0, src_b_q} + {1'b0, len_q};
        end_dst   = {1'b0, dst_q} + {1'b0, len_q};
        range_bad = (end_a > DEPTH_W) || (end_b > DEPTH_W) || (end_dst > DEPTH_W);
        last_elem = (idx_q == (len_q - ONE));
    end

    // Next-state logic; bus outputs are computed for the state being entered
    // so the registered values line up with that state's cycle.
    always_comb begin
        state_d = state_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        a_d     = a_q;
        busy_d  = busy_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_a_d = src_a;
                    src_b_d = src_b;
                    dst_d   = dst;
                    len_d   = len;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_q == '0) begin
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else if (range_bad) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    idx_d   = '0;
                    cs_d    = 1'b1;
                    addr_d  = src_a_q;
                    state_d = ST_RD_A;
                end
            end
            ST_RD_A: begin
                cs_d    = 1'b1;
                addr_d  = src_b_q + idx_q;
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                a_d     = mem_readdata;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_q + idx_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                ovf_d = ovf_q | sum_w[DATA_W];
                if (last_elem) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + ONE;
                    cs_d    = 1'b1;
                    addr_d  = src_a_q + idx_q + ONE;
                    state_d = ST_RD_A;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel wins over everything outside IDLE; a write already on the
        // bus this cycle still lands because its controls are registered.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign ovf            = ovf_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    // B[i] only arrives in the WR cycle, so the sum cannot be registered
    // ahead of the write; it is gated by the registered write strobe.
    assign mem_writedata  = wr_q ? sum_w[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_vectadd_engine.sv
// Directed bench for vectadd_engine with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_vectadd_engine;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int DEP = 12500;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_a = '0, src_b = '0, dst = '0, len = '0;
    logic          abort = 1'b0;
    logic          busy, done, err, ovf;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW/8-1:0] mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata = '0;

    logic [DW-1:0] ram [0:DEP-1];
    int            cs_cnt = 0;
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    vectadd_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .src_a          (src_a),
        .src_b          (src_b),
        .dst            (dst),
        .len            (len),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .ovf            (ovf),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // RAM port s2 model: registered read, write on the edge.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (int'(mem_address) < DEP) begin
                if (mem_write) ram[mem_address] <= mem_writedata;
                else           mem_readdata     <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one job and wait (bounded) for done. done_cyc = -1 on timeout.
    task automatic run_job(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                           input logic [AW-1:0] ds, input logic [AW-1:0] ln,
                           input logic with_abort,
                           output int done_cyc, output logic err_o, output logic ovf_o);
        done_cyc = -1;
        err_o    = 1'b0;
        ovf_o    = 1'b0;
        @(negedge clk);
        src_a = sa; src_b = sb; dst = ds; len = ln;
        start = 1'b1;
        abort = with_abort;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (c == 1) chk("busy_in_check", {31'd0, busy}, 32'd1);
            if (done) begin
                done_cyc = c;
                err_o    = err;
                ovf_o    = ovf;
                chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"},  {31'd0, err},  32'd0);
        chk({tag, "_ovf"},  {31'd0, ovf},  32'd0);
        chk({tag, "_cs"},   {31'd0, mem_chipselect}, 32'd0);
        chk({tag, "_wr"},   {31'd0, mem_write}, 32'd0);
        chk({tag, "_addr"}, {18'd0, mem_address}, 32'd0);
        chk({tag, "_wdata"}, mem_writedata, 32'd0);
    endtask

    int          dc;
    logic        e_o, o_o;
    int          cs_before;
    logic [31:0] old_a [0:7];
    logic [31:0] bvals [0:7];
    bit          saw_done;

    initial begin
        for (int k = 0; k < DEP; k++) ram[k] = 32'hA5A5_0000 | k;

        #12;
        check_reset_outputs("reset");
        chk("byteenable", {28'd0, mem_byteenable}, 32'h0000_000F);
        chk("clken", {31'd0, mem_clken}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic 4-element job; a simultaneous abort in IDLE must be ignored.
        for (int k = 0; k < 4; k++) begin
            ram[k]     = k + 1;
            ram[100+k] = 10 * (k + 1);
        end
        run_job(0, 100, 200, 4, 1'b1, dc, e_o, o_o);
        chk("basic_done_cycle", dc, 32'd14);
        chk("basic_err", {31'd0, e_o}, 32'd0);
        chk("basic_ovf", {31'd0, o_o}, 32'd0);
        chk("basic_c0", ram[200], 32'd11);
        chk("basic_c1", ram[201], 32'd22);
        chk("basic_c2", ram[202], 32'd33);
        chk("basic_c3", ram[203], 32'd44);
        chk("basic_c4_untouched", ram[204], 32'hA5A5_00CC);

        // Carry out of the adder sets ovf; result wraps.
        ram[500] = 32'hFFFF_FFFF;
        ram[501] = 32'd2;
        run_job(500, 501, 502, 1, 1'b0, dc, e_o, o_o);
        chk("ovf_done_cycle", dc, 32'd5);
        chk("ovf_flag", {31'd0, o_o}, 32'd1);
        chk("ovf_err", {31'd0, e_o}, 32'd0);
        chk("ovf_sum", ram[502], 32'h0000_0001);

        // Next job clears ovf.
        ram[510] = 32'd5;
        ram[511] = 32'd6;
        run_job(510, 511, 512, 1, 1'b0, dc, e_o, o_o);
        chk("ovf_cleared", {31'd0, o_o}, 32'd0);
        chk("ovf_cleared_sum", ram[512], 32'd11);

        // Zero length: done in cycle 2, no bus activity.
        cs_before = cs_cnt;
        run_job(0, 0, 0, 0, 1'b0, dc, e_o, o_o);
        chk("len0_done_cycle", dc, 32'd2);
        chk("len0_err", {31'd0, e_o}, 32'd0);
        chk("len0_no_cs", cs_cnt - cs_before, 32'd0);

        // Destination overruns the RAM end (12498+3 > 12500): rejected.
        cs_before = cs_cnt;
        run_job(0, 0, 12498, 3, 1'b0, dc, e_o, o_o);
        chk("range_done_cycle", dc, 32'd2);
        chk("range_err", {31'd0, e_o}, 32'd1);
        chk("range_no_cs", cs_cnt - cs_before, 32'd0);
        chk("range_ram_12498", ram[12498], 32'hA5A5_30D2);
        chk("range_ram_12499", ram[12499], 32'hA5A5_30D3);

        // Exactly at the end (12497+3 == 12500) is legal.
        ram[12497] = 32'd7; ram[12498] = 32'd8; ram[12499] = 32'd9;
        run_job(12497, 12497, 12497, 3, 1'b0, dc, e_o, o_o);
        chk("edge_err", {31'd0, e_o}, 32'd0);
        chk("edge_done_cycle", dc, 32'd11);
        chk("edge_c2", ram[12499], 32'd18);

        // In place: dst == src_a.
        for (int k = 0; k < 8; k++) begin
            old_a[k]    = 32'h100 * (k + 1) + k;
            bvals[k]    = 32'h1000_0000 + 3 * k;
            ram[k]      = old_a[k];
            ram[1000+k] = bvals[k];
        end
        run_job(0, 1000, 0, 8, 1'b0, dc, e_o, o_o);
        chk("inplace_done_cycle", dc, 32'd26);
        for (int k = 0; k < 8; k++)
            chk($sformatf("inplace_c%0d", k), ram[k], old_a[k] + bvals[k]);

        // Abort in element 2's RD_B (cycle 9): elements 0..1 written, no done.
        for (int k = 0; k < 4; k++) begin
            ram[k]     = 32'd50 + k;
            ram[100+k] = 32'd1;
            ram[300+k] = 32'hDEAD_0000 + k;
        end
        @(negedge clk);
        src_a = 0; src_b = 100; dst = 300; len = 4;
        start = 1'b1;
        saw_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == 9);
            if (c == 10) begin
                chk("abort_busy_low", {31'd0, busy}, 32'd0);
                chk("abort_cs_low", {31'd0, mem_chipselect}, 32'd0);
            end
            if (done) saw_done = 1'b1;
        end
        abort = 1'b0;
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_c0", ram[300], 32'd51);
        chk("abort_c1", ram[301], 32'd52);
        chk("abort_c2_untouched", ram[302], 32'hDEAD_0002);
        chk("abort_c3_untouched", ram[303], 32'hDEAD_0003);

        // Reset during element 1's RD_A on a second run.
        for (int k = 0; k < 4; k++) ram[400+k] = 32'hBEEF_0000 + k;
        @(negedge clk);
        src_a = 0; src_b = 100; dst = 400; len = 4;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        cs_before = cs_cnt;
        repeat (6) @(negedge clk);
        chk("midreset_no_cs", cs_cnt - cs_before, 32'd0);
        chk("midreset_c0", ram[400], 32'd51);
        chk("midreset_c1_untouched", ram[401], 32'hBEEF_0001);

        // Normal job after reset.
        run_job(0, 100, 600, 2, 1'b0, dc, e_o, o_o);
        chk("post_done_cycle", dc, 32'd8);
        chk("post_err", {31'd0, e_o}, 32'd0);
        chk("post_c0", ram[600], 32'd51);
        chk("post_c1", ram[601], 32'd52);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
